// File: rtl/ws2812_frame_scanner_if.sv
// Bundle of the scanner's start/host/framebuffer/serializer signals.
// The master modport is the scanner side; slave is the surrounding system.
interface ws2812_frame_scanner_if;
    logic        start;
    logic        clear_req;
    logic        clear_ack;
    logic        host_wr_req;
    logic [7:0]  host_row;
    logic [7:0]  host_column;
    logic        host_wr_ack;
    logic [7:0]  mem_row;
    logic [7:0]  mem_column;
    logic [7:0]  mem_r;
    logic [7:0]  mem_g;
    logic [7:0]  mem_b;
    logic        mem_write;
    logic        mem_clear;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        frame_done;

    modport master (
        input  start, clear_req, host_wr_req, host_row, host_column,
               mem_r, mem_g, mem_b, pix_ready,
        output clear_ack, host_wr_ack, mem_row, mem_column, mem_write,
               mem_clear, pix_data, pix_valid, busy, frame_done
    );

    modport slave (
        output start, clear_req, host_wr_req, host_row, host_column,
               mem_r, mem_g, mem_b, pix_ready,
        input  clear_ack, host_wr_ack, mem_row, mem_column, mem_write,
               mem_clear, pix_data, pix_valid, busy, frame_done
    );
endinterface

// File: rtl/ws2812_frame_scanner.sv
// Frame scanner for the ws2812 matrix: walks pixels in chain order, feeds GRB words to the
// serializer, holds the latch gap, and admits host writes/clears only between frames.
module ws2812_frame_scanner #(
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 16,
    parameter int SERPENTINE   = 1,
    parameter int LATCH_CYCLES = 4000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ws2812_frame_scanner_if.master  bus
);

    localparam int XW = (WIDTH > 1)        ? $clog2(WIDTH)        : 1;
    localparam int YW = (HEIGHT > 1)       ? $clog2(HEIGHT)       : 1;
    localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_PRESENT = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_HW_ADDR = 3'd4;
    localparam logic [2:0] S_HW_STRB = 3'd5;
    localparam logic [2:0] S_CLR     = 3'd6;

    logic [2:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] latch_cnt;
    logic          start_pending;
    logic          ret_latch;
    logic [7:0]    hw_row;
    logic [7:0]    hw_col;
    logic [23:0]   pix_data_q;
    logic          pix_valid_q;
    logic          frame_done_q;
    logic [XW-1:0] scan_col;

    // Odd rows run right-to-left on a serpentine-wired panel.
    always_comb begin
        scan_col = x;
        if (SERPENTINE != 0 && y[0]) begin
            scan_col = X_LAST - x;
        end
    end

    always_comb begin
        bus.mem_row    = 8'd0;
        bus.mem_column = 8'd0;
        case (state)
            S_FETCH: begin
                bus.mem_row    = 8'(y);
                bus.mem_column = 8'(scan_col);
            end
            S_HW_ADDR, S_HW_STRB: begin
                bus.mem_row    = hw_row;
                bus.mem_column = hw_col;
            end
            default: begin
                bus.mem_row    = 8'd0;
                bus.mem_column = 8'd0;
            end
        endcase
    end

    assign bus.mem_write   = (state == S_HW_STRB);
    assign bus.host_wr_ack = (state == S_HW_STRB);
    assign bus.mem_clear   = (state == S_CLR);
    assign bus.clear_ack   = (state == S_CLR);
    assign bus.busy        = (state == S_FETCH) || (state == S_PRESENT) || (state == S_LATCH);
    assign bus.pix_data    = pix_data_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.frame_done  = frame_done_q;

    // ret_latch remembers whether a host access interrupted the latch gap, so the frozen
    // counter resumes there instead of dropping straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            latch_cnt     <= '0;
            start_pending <= 1'b0;
            ret_latch     <= 1'b0;
            hw_row        <= 8'd0;
            hw_col        <= 8'd0;
            pix_data_q    <= 24'd0;
            pix_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (bus.start) begin
                start_pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.clear_req) begin
                        state     <= S_CLR;
                        ret_latch <= 1'b0;
                    end else if (bus.host_wr_req) begin
                        state     <= S_HW_ADDR;
                        ret_latch <= 1'b0;
                        hw_row    <= bus.host_row;
                        hw_col    <= bus.host_column;
                    end else if (start_pending) begin
                        state         <= S_FETCH;
                        start_pending <= bus.start;
                    end
                end
                S_FETCH: begin
                    pix_data_q  <= {bus.mem_g, bus.mem_r, bus.mem_b};
                    pix_valid_q <= 1'b1;
                    state       <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (pix_valid_q && bus.pix_ready) begin
                        pix_valid_q <= 1'b0;
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y         <= '0;
                                latch_cnt <= LATCH_LOAD;
                                state     <= S_LATCH;
                            end else begin
                                y     <= y + 1'b1;
                                state <= S_FETCH;
                            end
                        end else begin
                            x     <= x + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (bus.clear_req) begin
                        state     <= S_CLR;
                        ret_latch <= 1'b1;
                    end else if (bus.host_wr_req) begin
                        state     <= S_HW_ADDR;
                        ret_latch <= 1'b1;
                        hw_row    <= bus.host_row;
                        hw_col    <= bus.host_column;
                    end else if (latch_cnt == '0) begin
                        state        <= S_IDLE;
                        frame_done_q <= 1'b1;
                    end else begin
                        latch_cnt <= latch_cnt - 1'b1;
                    end
                end
                S_HW_ADDR: begin
                    state <= S_HW_STRB;
                end
                S_HW_STRB, S_CLR: begin
                    state <= ret_latch ? S_LATCH : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_scanner.sv
// Directed bench for ws2812_frame_scanner on a 2x2 serpentine panel with a 3-cycle latch gap.
module tb_ws2812_frame_scanner;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int LC = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ws2812_frame_scanner_if bus();

    ws2812_frame_scanner #(
        .WIDTH(W), .HEIGHT(H), .SERPENTINE(1), .LATCH_CYCLES(LC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [7:0] fb_r [2][2];
    logic [7:0] fb_g [2][2];
    logic [7:0] fb_b [2][2];

    // Combinational framebuffer model addressed by the scanner.
    always_comb begin
        bus.mem_r = 8'd0;
        bus.mem_g = 8'd0;
        bus.mem_b = 8'd0;
        if (bus.mem_row < 8'd2 && bus.mem_column < 8'd2) begin
            bus.mem_r = fb_r[bus.mem_row[0]][bus.mem_column[0]];
            bus.mem_g = fb_g[bus.mem_row[0]][bus.mem_column[0]];
            bus.mem_b = fb_b[bus.mem_row[0]][bus.mem_column[0]];
        end
    end

    typedef struct {
        logic [7:0]  row;
        logic [7:0]  col;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [23:0] exp_data;
    } pix_vec_t;

    pix_vec_t vecs [4];

    int vec_count  = 0;
    int miss_count = 0;

    logic [7:0] prev_row;
    logic [7:0] prev_col;
    logic       prev_wr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input pix_vec_t v);
        fb_r[v.row[0]][v.col[0]] = v.r;
        fb_g[v.row[0]][v.col[0]] = v.g;
        fb_b[v.row[0]][v.col[0]] = v.b;
    endtask

    // Advance to the next falling edge, remembering what the bus showed at this one.
    task automatic stepNeg();
        prev_row = bus.mem_row;
        prev_col = bus.mem_column;
        prev_wr  = bus.mem_write;
        @(negedge clk);
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        stepNeg();
        bus.start = 1'b0;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!bus.pix_valid && n < 50) begin
            stepNeg();
            n++;
        end
        checkOutput(name, {31'd0, bus.pix_valid}, 32'd1);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!bus.frame_done && n < 60) begin
            stepNeg();
            n++;
        end
        checkOutput(name, {31'd0, bus.frame_done}, 32'd1);
        stepNeg();
    endtask

    initial begin
        int n;
        int idx;
        int hs;
        int last_hs;
        int wr_idx;
        int hs_at_wr;
        int done_idx;
        int clr_idx;
        int hw_idx;
        int good;
        int dones;
        int bad;
        logic [15:0] wr_addr;
        logic [15:0] wr_prev_addr;
        logic        wr_prev_wr;
        logic        wr_ack;
        logic        clr_strobe;
        logic [15:0] hw_addr;
        logic        after_done;
        logic        busy_after_first;

        bus.start       = 1'b0;
        bus.clear_req   = 1'b0;
        bus.host_wr_req = 1'b0;
        bus.host_row    = 8'd0;
        bus.host_column = 8'd0;
        bus.pix_ready   = 1'b1;

        // Scan order on a 2x2 serpentine panel: row 1 runs right-to-left.
        vecs[0] = '{8'd0, 8'd0, 8'h11, 8'h22, 8'h33, 24'h221133};
        vecs[1] = '{8'd0, 8'd1, 8'h44, 8'h55, 8'h66, 24'h554466};
        vecs[2] = '{8'd1, 8'd1, 8'h77, 8'h88, 8'h99, 24'h887799};
        vecs[3] = '{8'd1, 8'd0, 8'haa, 8'hbb, 8'hcc, 24'hbbaacc};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_strobes", {25'd0, bus.pix_valid, bus.busy, bus.mem_write, bus.mem_clear,
                    bus.frame_done, bus.clear_ack, bus.host_wr_ack}, 32'd0);
        checkOutput("reset_addr", {16'd0, bus.mem_row, bus.mem_column}, 32'd0);
        checkOutput("reset_pix_data", {8'd0, bus.pix_data}, 32'd0);
        rst_n = 1'b1;
        repeat (3) stepNeg();
        checkOutput("idle_no_start", {31'd0, bus.busy}, 32'd0);

        // Plain frame with the serializer always ready.
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(bus.pix_valid && bus.pix_ready) && n < 20) begin
                stepNeg();
                n++;
            end
            checkOutput($sformatf("pix%0d_data", i), {8'd0, bus.pix_data}, {8'd0, vecs[i].exp_data});
            checkOutput($sformatf("pix%0d_addr", i), {16'd0, prev_row, prev_col},
                        {16'd0, vecs[i].row, vecs[i].col});
            stepNeg();
        end
        n = 1;
        while (!bus.frame_done && n < 20) begin
            stepNeg();
            n++;
        end
        checkOutput("frame_done_latency", n, 32'd4);
        checkOutput("busy_at_frame_done", {31'd0, bus.busy}, 32'd0);
        stepNeg();
        checkOutput("frame_done_width", {31'd0, bus.frame_done}, 32'd0);

        // Backpressure: the first word must sit unchanged while the serializer stalls.
        bus.pix_ready = 1'b0;
        pulseStart();
        waitValid("bp_valid");
        checkOutput("bp_data", {8'd0, bus.pix_data}, 32'h00221133);
        good = 0;
        for (int i = 0; i < 10; i++) begin
            stepNeg();
            if (bus.pix_valid === 1'b1 && bus.pix_data === 24'h221133) begin
                good++;
            end
        end
        checkOutput("bp_hold_cycles", good, 32'd10);
        bus.pix_ready = 1'b1;
        waitDone("bp_frame_done");

        // Host write requested mid-frame is held off until the latch gap.
        bus.pix_ready = 1'b0;
        pulseStart();
        waitValid("hw_valid");
        bus.host_row    = 8'd1;
        bus.host_column = 8'd0;
        bus.host_wr_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            stepNeg();
            if (bus.mem_write !== 1'b0) begin
                bad++;
            end
        end
        checkOutput("hw_stall_no_write", bad, 32'd0);
        bus.pix_ready = 1'b1;
        idx = 0; hs = 0; last_hs = -1; wr_idx = -1; hs_at_wr = -1; done_idx = -1;
        wr_addr = 16'd0; wr_prev_addr = 16'd0; wr_prev_wr = 1'b1; wr_ack = 1'b0;
        while (idx < 40) begin
            if (bus.pix_valid && bus.pix_ready) begin
                hs++;
                last_hs = idx;
            end
            if (bus.mem_write && wr_idx < 0) begin
                wr_idx       = idx;
                hs_at_wr     = hs;
                wr_addr      = {bus.mem_row, bus.mem_column};
                wr_prev_addr = {prev_row, prev_col};
                wr_prev_wr   = prev_wr;
                wr_ack       = bus.host_wr_ack;
                bus.host_wr_req = 1'b0;
            end
            if (bus.frame_done) begin
                done_idx = idx;
                break;
            end
            stepNeg();
            idx++;
        end
        checkOutput("hw_after_all_pixels", hs_at_wr, 32'd4);
        checkOutput("hw_write_delay", wr_idx - last_hs, 32'd3);
        checkOutput("hw_ack", {31'd0, wr_ack}, 32'd1);
        checkOutput("hw_addr", {16'd0, wr_addr}, 32'h0100);
        checkOutput("hw_setup_addr", {16'd0, wr_prev_addr}, 32'h0100);
        checkOutput("hw_setup_no_strobe", {31'd0, wr_prev_wr}, 32'd0);
        checkOutput("hw_latch_frozen", done_idx - last_hs, 32'd7);
        repeat (2) stepNeg();

        // Clear and host write raised together in IDLE: clear wins, write follows.
        bus.host_row    = 8'd0;
        bus.host_column = 8'd1;
        bus.clear_req   = 1'b1;
        bus.host_wr_req = 1'b1;
        idx = 0; clr_idx = -1; hw_idx = -1; clr_strobe = 1'b0; hw_addr = 16'd0;
        while (idx < 20) begin
            if (bus.clear_ack && clr_idx < 0) begin
                clr_idx       = idx;
                clr_strobe    = bus.mem_clear;
                bus.clear_req = 1'b0;
            end
            if (bus.host_wr_ack) begin
                hw_idx          = idx;
                hw_addr         = {bus.mem_row, bus.mem_column};
                bus.host_wr_req = 1'b0;
                break;
            end
            stepNeg();
            idx++;
        end
        checkOutput("clr_first_delay", clr_idx, 32'd1);
        checkOutput("clr_strobe", {31'd0, clr_strobe}, 32'd1);
        checkOutput("clr_then_hw_gap", hw_idx - clr_idx, 32'd3);
        checkOutput("clr_then_hw_addr", {16'd0, hw_addr}, 32'h0001);
        repeat (2) stepNeg();

        // A start arriving mid-frame queues exactly one more frame.
        bus.pix_ready = 1'b0;
        pulseStart();
        waitValid("b2b_valid");
        pulseStart();
        bus.pix_ready = 1'b1;
        dones = 0; after_done = 1'b0; busy_after_first = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (after_done && dones == 1) begin
                busy_after_first = bus.busy;
            end
            after_done = bus.frame_done;
            if (bus.frame_done) begin
                dones++;
            end
            stepNeg();
        end
        checkOutput("b2b_frame_count", dones, 32'd2);
        checkOutput("b2b_restart", {31'd0, busy_after_first}, 32'd1);
        checkOutput("b2b_idle_after", {31'd0, bus.busy}, 32'd0);

        // Reset while a word is presented, with another start still pending.
        bus.pix_ready = 1'b0;
        pulseStart();
        waitValid("rst_valid");
        pulseStart();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid_busy", {30'd0, bus.pix_valid, bus.busy}, 32'd0);
        checkOutput("rst_async_mem", {14'd0, bus.mem_write, bus.mem_clear, bus.mem_row, bus.mem_column}, 32'd0);
        checkOutput("rst_async_data", {8'd0, bus.pix_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pix_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            stepNeg();
            if (bus.busy || bus.pix_valid) begin
                bad++;
            end
        end
        checkOutput("rst_drops_pending", bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
